// File: rtl/seq_gen_pkg.sv
// -----------------------------------------------------------------------------
// seq_gen_pkg
// Shared types and constants for the programmable sequence generator.
//   state_t      : FSM state encoding (1 bit, IDLE/RUN)
//   MODE_*       : loop / one-shot mode values carried in mode_in / mode_r
//   LEGACY_*     : the original fixed "001011" pattern, used as reset defaults
// -----------------------------------------------------------------------------
package seq_gen_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic MODE_LOOP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    // LSB first this emits 0,0,1,0,1,1; the stored length is length-minus-one.
    localparam logic [15:0] LEGACY_PAT = 16'h0034;
    localparam int          LEGACY_LEN = 5;

endpackage

// File: rtl/seq_gen_prog_if.sv
// -----------------------------------------------------------------------------
// seq_gen_prog_if
// Control/observation bundle for seq_gen_prog.
//   master : drives load/pat_in/len_in/mode_in/start/stop/en, observes outputs
//   slave  : the generator itself
// Signalling: there is no valid/ready back-pressure. load, start and stop are
// single-cycle request pulses sampled on the rising edge; en is a level that
// stalls the sequence while low. data is meaningful only while data_vld is
// high, and last is qualified by data_vld. load_err is a one-cycle pulse.
// state mirrors the FSM register for observation.
// -----------------------------------------------------------------------------
interface seq_gen_prog_if
    import seq_gen_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN)
) ();

    logic               load;
    logic [MAX_LEN-1:0] pat_in;
    logic [LEN_W-1:0]   len_in;
    logic               mode_in;
    logic               start;
    logic               stop;
    logic               en;
    logic               data;
    logic               data_vld;
    logic               last;
    logic               busy;
    logic               load_err;
    state_t             state;

    modport master (
        output load, pat_in, len_in, mode_in, start, stop, en,
        input  data, data_vld, last, busy, load_err, state
    );

    modport slave (
        input  load, pat_in, len_in, mode_in, start, stop, en,
        output data, data_vld, last, busy, load_err, state
    );

endinterface

// File: rtl/seq_gen_idx_cnt.sv
// -----------------------------------------------------------------------------
// seq_gen_idx_cnt
// Pattern bit index that wraps to zero after reaching len.
//   clk, rst_n : clock, async active-low reset
//   clr        : force idx to 0 (takes priority over adv)
//   adv        : step idx by one, wrapping after len
//   len        : pattern length minus one (already clamped by the caller)
//   idx        : current bit index
//   wrap       : idx equals len, i.e. the current bit is the final one
// -----------------------------------------------------------------------------
module seq_gen_idx_cnt #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             adv,
    input  logic [LEN_W-1:0] len,
    output logic [LEN_W-1:0] idx,
    output logic             wrap
);

    logic [LEN_W-1:0] idx_r;

    assign idx  = idx_r;
    assign wrap = (idx_r == len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r <= '0;
        end else if (clr) begin
            idx_r <= '0;
        end else if (adv) begin
            idx_r <= wrap ? '0 : idx_r + LEN_W'(1);
        end
    end

endmodule

// File: rtl/seq_gen_prog.sv
// -----------------------------------------------------------------------------
// seq_gen_prog
// Programmable serial sequence generator. Emits a loadable pattern of
// 1..MAX_LEN bits, LSB first, in loop or one-shot mode.
//   clk, rst_n : clock, async active-low reset
//   bus        : seq_gen_prog_if slave (config/control in, serial data and
//                status out, FSM state for observation)
// Out of reset the config holds the legacy 001011 pattern in loop mode and,
// with AUTO_START set, the FSM starts in RUN so the legacy stream appears
// without any programming.
// -----------------------------------------------------------------------------
module seq_gen_prog
    import seq_gen_pkg::*;
#(
    parameter int                 MAX_LEN     = 16,
    parameter int                 LEN_W       = $clog2(MAX_LEN),
    parameter logic [MAX_LEN-1:0] DEFAULT_PAT = MAX_LEN'(LEGACY_PAT),
    parameter int                 DEFAULT_LEN = LEGACY_LEN,
    parameter bit                 AUTO_START  = 1'b1
) (
    input logic           clk,
    input logic           rst_n,
    seq_gen_prog_if.slave bus
);

    localparam state_t           RST_STATE = AUTO_START ? ST_RUN : ST_IDLE;
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN - 1);

    state_t             state_r, state_nxt;
    logic [MAX_LEN-1:0] pat_r;
    logic [LEN_W-1:0]   len_r;
    logic               mode_r;
    logic [LEN_W-1:0]   idx;
    logic               wrap;
    logic               cfg_we, cnt_clr, cnt_adv;
    logic [LEN_W-1:0]   len_clamped;
    logic               data_r, vld_r, last_r, lerr_r;

    // Only matters when MAX_LEN is not a power of two and len_in can encode
    // lengths beyond the pattern register.
    assign len_clamped = (bus.len_in > LEN_MAX) ? LEN_MAX : bus.len_in;

    seq_gen_idx_cnt #(.LEN_W(LEN_W)) u_idx_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .adv   (cnt_adv),
        .len   (len_r),
        .idx   (idx),
        .wrap  (wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RST_STATE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // cnt_adv doubles as "a pattern bit is emitted on this edge".
    always_comb begin
        state_nxt = state_r;
        cfg_we    = 1'b0;
        cnt_clr   = 1'b0;
        cnt_adv   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.load) begin
                    cfg_we  = 1'b1;
                    cnt_clr = 1'b1;
                end else if (bus.start) begin
                    state_nxt = ST_RUN;
                    cnt_clr   = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_nxt = ST_IDLE;
                    cnt_clr   = 1'b1;
                end else if (bus.en) begin
                    cnt_adv = 1'b1;
                    // One-shot leaves RUN on the same edge that emits last;
                    // the counter wraps to 0 by itself.
                    if (wrap && (mode_r == MODE_ONESHOT)) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_r  <= DEFAULT_PAT;
            len_r  <= LEN_W'(DEFAULT_LEN);
            mode_r <= MODE_LOOP;
        end else if (cfg_we) begin
            pat_r  <= bus.pat_in;
            len_r  <= len_clamped;
            mode_r <= bus.mode_in;
        end
    end

    // data holds its last value whenever no bit is emitted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= 1'b0;
            vld_r  <= 1'b0;
            last_r <= 1'b0;
            lerr_r <= 1'b0;
        end else begin
            if (cnt_adv) begin
                data_r <= pat_r[idx];
            end
            vld_r  <= cnt_adv;
            last_r <= cnt_adv && wrap;
            lerr_r <= (state_r == ST_RUN) && bus.load;
        end
    end

    assign bus.data     = data_r;
    assign bus.data_vld = vld_r;
    assign bus.last     = last_r;
    assign bus.load_err = lerr_r;
    assign bus.busy     = (state_r == ST_RUN);
    assign bus.state    = state_r;

endmodule
